// File: rtl/fetch_redirect_arbiter_pkg.sv
// Shared encodings for the fetch redirect arbiter: source identities, FSM states
// and the fixed priority ranking between redirect sources.
package fetch_redirect_arbiter_pkg;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_COMMIT = 2'd1,
    SRC_EXEC   = 2'd2,
    SRC_DECODE = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Smaller rank wins; SRC_NONE ranks below every real source.
  function automatic logic [1:0] srcRank(input src_e src);
    case (src)
      SRC_COMMIT: srcRank = 2'd0;
      SRC_EXEC:   srcRank = 2'd1;
      SRC_DECODE: srcRank = 2'd2;
      default:    srcRank = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/fetch_redirect_arbiter_if.sv
// Redirect request channels from commit/execute/decode plus the fetch-issue
// update port and status outputs of the redirect arbiter.
interface fetch_redirect_arbiter_if #(
  parameter int NLP_UPDATE = 71,
  parameter int CNT_WIDTH  = 16
);
  logic                  commit_redirect_valid;
  logic                  commit_redirect_ready;
  logic [NLP_UPDATE-1:0] commit_redirect_data;
  logic                  exec_redirect_valid;
  logic                  exec_redirect_ready;
  logic [NLP_UPDATE-1:0] exec_redirect_data;
  logic                  decode_redirect_valid;
  logic                  decode_redirect_ready;
  logic [NLP_UPDATE-1:0] decode_redirect_data;
  logic                  fetch_update_valid;
  logic                  fetch_update_ready;
  logic [NLP_UPDATE-1:0] fetch_update_data;
  logic                  fetch_flush;
  logic [1:0]            held_source;
  logic [CNT_WIDTH-1:0]  drop_count;

  modport master (
    output commit_redirect_valid, commit_redirect_data,
    output exec_redirect_valid, exec_redirect_data,
    output decode_redirect_valid, decode_redirect_data,
    output fetch_update_ready,
    input  commit_redirect_ready, exec_redirect_ready, decode_redirect_ready,
    input  fetch_update_valid, fetch_update_data, fetch_flush,
    input  held_source, drop_count
  );

  modport slave (
    input  commit_redirect_valid, commit_redirect_data,
    input  exec_redirect_valid, exec_redirect_data,
    input  decode_redirect_valid, decode_redirect_data,
    input  fetch_update_ready,
    output commit_redirect_ready, exec_redirect_ready, decode_redirect_ready,
    output fetch_update_valid, fetch_update_data, fetch_flush,
    output held_source, drop_count
  );
endinterface

// File: rtl/fetch_redirect_arbiter.sv
// Fixed-priority arbiter (commit > exec > decode) for the single PC update port
// of fetch issue. The winning redirect is held in an output register until fetch
// accepts it; a higher-priority redirect may replace it while it waits. After each
// acceptance, decode corrections are blanked for BLANK_CYCLES cycles.
module fetch_redirect_arbiter
  import fetch_redirect_arbiter_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NLP_UPDATE   = 71,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input logic                    clock,
  input logic                    reset,
  fetch_redirect_arbiter_if.slave bus
);

  localparam int BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BlankW-1:0] BlankLoad = (BLANK_CYCLES > 0) ? BlankW'(BLANK_CYCLES - 1) : '0;

  // The target PC lives in the low XLEN bits, so the payload must hold at least that much.
  if (NLP_UPDATE < XLEN) begin : g_payloadTooNarrow
    $error("fetch_redirect_arbiter: NLP_UPDATE must be at least XLEN");
  end

  state_e                r_state, w_nextState;
  logic                  r_valid, w_nextValid;
  logic [NLP_UPDATE-1:0] r_data, w_nextData;
  src_e                  r_src, w_nextSrc;
  logic                  r_flush, w_nextFlush;
  logic [BlankW-1:0]     r_blankCnt, w_nextBlankCnt;
  logic [CNT_WIDTH-1:0]  r_dropCount;

  // Bit 0 = commit, bit 1 = exec, bit 2 = decode.
  logic [2:0]            w_ready, w_take, w_eligible;
  src_e                  w_winSrc;
  logic [NLP_UPDATE-1:0] w_winData;
  logic                  w_capture, w_replaceDrop;
  logic [1:0]            w_numTakes, w_drops;
  logic [CNT_WIDTH:0]    w_dropSum;

  // A source is refused only while its own redirect is the one being held; all refused in reset.
  always_comb begin
    w_ready = {3{reset}};
    if (r_state == ST_HOLD) begin
      w_ready[0] = reset && (r_src != SRC_COMMIT);
      w_ready[1] = reset && (r_src != SRC_EXEC);
      w_ready[2] = reset && (r_src != SRC_DECODE);
    end
  end

  assign w_take = w_ready & {bus.decode_redirect_valid, bus.exec_redirect_valid,
                             bus.commit_redirect_valid};

  // Pick which consumed requests may become the held redirect, then the highest of them.
  always_comb begin
    w_eligible = '0;
    w_winSrc   = SRC_NONE;
    w_winData  = '0;
    case (r_state)
      ST_IDLE:  w_eligible = w_take;
      ST_BLANK: w_eligible = {1'b0, w_take[1:0]};
      ST_HOLD: begin
        w_eligible[0] = w_take[0] && (srcRank(SRC_COMMIT) < srcRank(r_src));
        w_eligible[1] = w_take[1] && (srcRank(SRC_EXEC)   < srcRank(r_src));
        w_eligible[2] = w_take[2] && (srcRank(SRC_DECODE) < srcRank(r_src));
      end
      default: w_eligible = '0;
    endcase
    if (w_eligible[0]) begin
      w_winSrc  = SRC_COMMIT;
      w_winData = bus.commit_redirect_data;
    end else if (w_eligible[1]) begin
      w_winSrc  = SRC_EXEC;
      w_winData = bus.exec_redirect_data;
    end else if (w_eligible[2]) begin
      w_winSrc  = SRC_DECODE;
      w_winData = bus.decode_redirect_data;
    end
  end

  assign w_capture     = |w_eligible;
  assign w_replaceDrop = w_capture && (r_state == ST_HOLD) && !bus.fetch_update_ready;

  // Every consumed request that is not captured is dropped, as is a held payload replaced unseen.
  always_comb begin
    w_numTakes = {1'b0, w_take[0]} + {1'b0, w_take[1]} + {1'b0, w_take[2]};
    w_drops    = w_numTakes - {1'b0, w_capture} + {1'b0, w_replaceDrop};
    w_dropSum  = {1'b0, r_dropCount} + {{(CNT_WIDTH - 1){1'b0}}, w_drops};
  end

  // Next-state and next-output selection for the IDLE/HOLD/BLANK controller.
  always_comb begin
    w_nextState    = r_state;
    w_nextValid    = r_valid;
    w_nextData     = r_data;
    w_nextSrc      = r_src;
    w_nextFlush    = 1'b0;
    w_nextBlankCnt = r_blankCnt;
    if (w_capture) begin
      w_nextState    = ST_HOLD;
      w_nextValid    = 1'b1;
      w_nextData     = w_winData;
      w_nextSrc      = w_winSrc;
      w_nextFlush    = 1'b1;
      w_nextBlankCnt = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (bus.fetch_update_ready) begin
            w_nextValid    = 1'b0;
            w_nextSrc      = SRC_NONE;
            w_nextBlankCnt = BlankLoad;
            w_nextState    = (BLANK_CYCLES > 0) ? ST_BLANK : ST_IDLE;
          end
        end
        ST_BLANK: begin
          if (r_blankCnt == '0) begin
            w_nextState = ST_IDLE;
          end else begin
            w_nextBlankCnt = r_blankCnt - 1'b1;
          end
        end
        default: w_nextState = r_state;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Held redirect, its source and the flush pulse; a reset discards anything held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= SRC_NONE;
      r_flush <= 1'b0;
    end else begin
      r_valid <= w_nextValid;
      r_data  <= w_nextData;
      r_src   <= w_nextSrc;
      r_flush <= w_nextFlush;
    end
  end

  // Remaining blanking cycles after an accepted redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_blankCnt <= '0;
    else        r_blankCnt <= w_nextBlankCnt;
  end

  // Saturating count of dropped requests.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_dropCount <= '0;
    else if (w_dropSum[CNT_WIDTH]) r_dropCount <= '1;
    else                        r_dropCount <= w_dropSum[CNT_WIDTH-1:0];
  end

  assign bus.commit_redirect_ready = w_ready[0];
  assign bus.exec_redirect_ready   = w_ready[1];
  assign bus.decode_redirect_ready = w_ready[2];
  assign bus.fetch_update_valid    = r_valid;
  assign bus.fetch_update_data     = r_data;
  assign bus.fetch_flush           = r_flush;
  assign bus.held_source           = r_src;
  assign bus.drop_count            = r_dropCount;

endmodule

// File: doc/fetch_redirect_arbiter.md
Name: fetch_redirect_arbiter

Overview:
- Shares the single PC update port of the out-of-order fetch issue stage between three redirect sources: commit (trap/exception), execute (branch mispredict) and decode (NLP correction).
- Fixed priority: commit > execute > decode. The winner is held in an output register until fetch issue accepts it.
- Pulses a flush to the fetch receive path whenever a new redirect is captured.
- After each accepted redirect, blanks stale decode corrections for a programmable window.

Parameters:
- XLEN, 64: PC width. Bits [XLEN-1:0] of every redirect payload hold the target PC.
- NLP_UPDATE, 71: payload width, carried opaquely to fetch_update_data.
- BLANK_CYCLES, 4: cycles after an accepted redirect during which decode redirects are dropped. 0 disables blanking.
- CNT_WIDTH, 16: width of the dropped-redirect counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- commit_redirect_valid  in  1  commit requests a redirect
- commit_redirect_ready  out  1  commit request consumed (captured or dropped)
- commit_redirect_data  in  NLP_UPDATE  commit payload
- exec_redirect_valid  in  1  execute requests a redirect
- exec_redirect_ready  out  1  execute request consumed
- exec_redirect_data  in  NLP_UPDATE  execute payload
- decode_redirect_valid  in  1  decode requests a redirect
- decode_redirect_ready  out  1  decode request consumed
- decode_redirect_data  in  NLP_UPDATE  decode payload
- fetch_update_valid  out  1  registered; held redirect present
- fetch_update_ready  in  1  fetch issue accepts the update
- fetch_update_data  out  NLP_UPDATE  registered held payload
- fetch_flush  out  1  registered one-cycle pulse, the cycle after each capture
- held_source  out  2  0 = none, 1 = commit, 2 = exec, 3 = decode
- drop_count  out  CNT_WIDTH  saturating count of dropped requests

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state IDLE
  - fetch_update_valid=0, fetch_update_data=0
  - fetch_flush=0, held_source=0, drop_count=0
  - blank counter=0
  - A held redirect is discarded if reset asserts mid-operation. All readies are 0 while reset is asserted.
- States: IDLE, HOLD, BLANK.
- Ready rule (combinational), outside reset:
  - In IDLE and BLANK, all three readies are 1.
  - In HOLD, a source's ready is 1 if and only if held_source is not that source.
  - A valid&&ready pair means the request is consumed. It is either captured or dropped; it is never retried.
- Capture in IDLE:
  - The highest-priority valid request wins.
  - Next cycle: state=HOLD, fetch_update_valid=1, fetch_update_data=winner payload, held_source=winner, fetch_flush=1.
  - Losing requests valid in the same cycle are dropped.
- BLANK:
  - Decode requests are always dropped.
  - Commit/exec requests are captured as in IDLE: go to HOLD and clear the blank counter.
  - Otherwise the counter decrements; when it reaches 0, go to IDLE next cycle.
- HOLD, no new request: hold data stable.
  - On fetch_update_ready: fetch_update_valid=0 and held_source=0 next cycle.
  - Next state is BLANK with counter=BLANK_CYCLES-1, or IDLE if BLANK_CYCLES=0.
- HOLD, higher-priority request:
  - It replaces the held payload next cycle, stays in HOLD and pulses fetch_flush.
  - The old payload is dropped, unless fetch_update_ready is high in the same cycle; then the old payload counts as delivered, not dropped.
  - This is the only case where fetch_update_data changes while valid && !ready.
- HOLD, lower-priority request: acked and dropped.
- HOLD, equal-priority request: ready=0, so the request stalls.
- Multiple simultaneous higher-priority requests in HOLD: the highest wins; the others are dropped.
- drop_count adds the number of requests dropped this cycle (0..3, including a replaced held payload) and saturates at all-ones.
- Latency: request consumed to fetch_update_valid is 1 cycle. No combinational path from any input to fetch_update_valid, fetch_update_data or fetch_flush.

Decomposition:
- Shared package holds:
  - source encodings SRC_NONE/COMMIT/EXEC/DECODE
  - state encodings
  - a function returning the priority rank of a source
- No sub-module is needed. Priority select and drop-count logic are inline. The blank counter may be a local always block.

Test Plan:
- Reset release, then decode_redirect_valid=1 with data=100 in IDLE:
  - decode_ready=1.
  - Next cycle: fetch_update_valid=1, data=100, held_source=3, fetch_flush=1 for exactly 1 cycle.
- Commit (data=0x200), exec (0x300) and decode (0x400) all valid in the same IDLE cycle:
  - All three readies=1.
  - Held data=0x200, held_source=1, drop_count=2.
- Exec 0x300 held with fetch_update_ready=0, then commit 0x500 arrives:
  - Replaced next cycle with data=0x500, held_source=1.
  - fetch_flush pulses again; drop_count increments by 1.
  - An exec request in the following cycle sees ready=1 and is dropped.
- Exec held, then fetch_update_ready=1 for one cycle with BLANK_CYCLES=4:
  - Decode requests in the next 4 cycles are acked and dropped, incrementing drop_count each cycle.
  - The fifth decode request is captured.
- Exec held and a second exec request arrives:
  - exec_ready=0 until the held update is accepted.
  - After acceptance the second exec request is captured during BLANK.
- Reset asserted while in HOLD:
  - fetch_update_valid=0 immediately (asynchronously), drop_count=0.
  - After release, state is IDLE and a new request is captured normally.
